// File: rtl/cu_sequencer.sv
// cu_sequencer: Moore control unit for the ARM-subset datapath (fetch, decode, DP, load/store, branch).
// Optional retired-instruction counter on instr_cnt is built only when CU_PERF_EN is defined.
module cu_sequencer #(
  parameter int DATA_W      = 32,
  parameter int MOC_TIMEOUT = 15,
  parameter int OP_W        = 5
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              moc,
  input  logic [DATA_W-1:0] ir,
  input  logic [3:0]        flags,
  output logic              rf_ld,
  output logic              ir_ld,
  output logic              mar_ld,
  output logic              mdr_ld,
  output logic              rw,
  output logic              mov,
  output logic [1:0]        data_type,
  output logic              fr_ld,
  output logic [OP_W-1:0]   alu_op,
  output logic [3:0]        state,
  output logic              fault,
  output logic [31:0]       instr_cnt
);

  localparam logic [3:0] S_RESET   = 4'd0;
  localparam logic [3:0] S_FETCH0  = 4'd1;
  localparam logic [3:0] S_FETCH1  = 4'd2;
  localparam logic [3:0] S_PC_INC  = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_DP_EXEC = 4'd5;
  localparam logic [3:0] S_LS_ADDR = 4'd6;
  localparam logic [3:0] S_LS_MEM  = 4'd7;
  localparam logic [3:0] S_LD_WB   = 4'd8;
  localparam logic [3:0] S_BR_EXEC = 4'd9;
  localparam logic [3:0] S_BL_LINK = 4'd10;
  localparam logic [3:0] S_FAULT   = 4'd15;

  localparam logic [OP_W-1:0] ALU_SUB      = OP_W'(5'h02);
  localparam logic [OP_W-1:0] ALU_ADD      = OP_W'(5'h04);
  localparam logic [OP_W-1:0] ALU_PC_OFS   = OP_W'(5'h10);
  localparam logic [OP_W-1:0] ALU_PASS_PC  = OP_W'(5'h11);
  localparam logic [OP_W-1:0] ALU_PC_INC   = OP_W'(5'h12);
  localparam logic [OP_W-1:0] ALU_PASS_MDR = OP_W'(5'h13);
  localparam logic [OP_W-1:0] ALU_LINK     = OP_W'(5'h14);

  localparam logic [1:0] DT_BYTE = 2'b00;
  localparam logic [1:0] DT_WORD = 2'b10;

  localparam logic [7:0] WAIT_LIMIT = 8'(MOC_TIMEOUT);

  logic [3:0] state_nx;
  logic [7:0] wait_cnt;
  logic       mem_state;
  logic       timeout;
  logic       is_load;
  logic       unused_ir;

  // Only ir[31:20] is decoded; the remaining bits are reserved for wider encodings.
  assign unused_ir = ^{ir, 1'b0};
  assign is_load   = ir[20];

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, res;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    res = z;
      4'h1:    res = !z;
      4'h2:    res = cy;
      4'h3:    res = !cy;
      4'h4:    res = n;
      4'h5:    res = !n;
      4'h6:    res = v;
      4'h7:    res = !v;
      4'h8:    res = cy && !z;
      4'h9:    res = !cy || z;
      4'hA:    res = (n == v);
      4'hB:    res = (n != v);
      4'hC:    res = !z && (n == v);
      4'hD:    res = z || (n != v);
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Wait counter is held at zero outside the memory states, so it starts from 0 on entry.
  assign mem_state = (state == S_FETCH1) || (state == S_LS_MEM);
  assign timeout   = !moc && (wait_cnt == WAIT_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (CLR || !mem_state) begin
      wait_cnt <= '0;
    end else if (!moc) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= S_RESET;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = S_FAULT;
    case (state)
      S_RESET:  state_nx = S_FETCH0;
      S_FETCH0: state_nx = S_FETCH1;
      S_FETCH1: begin
        if (moc)          state_nx = S_PC_INC;
        else if (timeout) state_nx = S_FAULT;
        else              state_nx = S_FETCH1;
      end
      S_PC_INC: state_nx = S_DECODE;
      S_DECODE: begin
        if (!cond_pass(ir[31:28], flags)) begin
          state_nx = S_FETCH0;
        end else begin
          case (ir[27:26])
            2'b00:   state_nx = S_DP_EXEC;
            2'b01:   state_nx = S_LS_ADDR;
            2'b10:   state_nx = S_BR_EXEC;
            default: state_nx = S_FAULT;
          endcase
        end
      end
      S_DP_EXEC: state_nx = S_FETCH0;
      S_LS_ADDR: state_nx = S_LS_MEM;
      S_LS_MEM: begin
        if (moc)          state_nx = is_load ? S_LD_WB : S_FETCH0;
        else if (timeout) state_nx = S_FAULT;
        else              state_nx = S_LS_MEM;
      end
      S_LD_WB:   state_nx = S_FETCH0;
      S_BR_EXEC: state_nx = ir[24] ? S_BL_LINK : S_FETCH0;
      S_BL_LINK: state_nx = S_FETCH0;
      default:   state_nx = S_FAULT;
    endcase
  end

  // IR/MDR loads are held for the whole memory state; the capture that matters
  // is the one on the edge where moc is high, which is also the state exit edge.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    rf_ld     = 1'b0;
    ir_ld     = 1'b0;
    mar_ld    = 1'b0;
    mdr_ld    = 1'b0;
    rw        = 1'b0;
    mov       = 1'b0;
    data_type = DT_WORD;
    fr_ld     = 1'b0;
    alu_op    = '0;
    fault     = 1'b0;
    case (state)
      S_FETCH0: begin
        mar_ld = 1'b1;
        alu_op = ALU_PASS_PC;
      end
      S_FETCH1: begin
        mov   = 1'b1;
        rw    = 1'b1;
        ir_ld = 1'b1;
      end
      S_PC_INC: begin
        rf_ld  = 1'b1;
        alu_op = ALU_PC_INC;
      end
      S_DP_EXEC: begin
        alu_op = OP_W'({1'b0, ir[24:21]});
        fr_ld  = ir[20];
        rf_ld  = (ir[24:23] != 2'b10);
      end
      S_LS_ADDR: begin
        mar_ld = 1'b1;
        alu_op = ir[23] ? ALU_ADD : ALU_SUB;
        mdr_ld = !is_load;
      end
      S_LS_MEM: begin
        mov       = 1'b1;
        rw        = is_load;
        data_type = ir[22] ? DT_BYTE : DT_WORD;
        mdr_ld    = is_load;
      end
      S_LD_WB: begin
        rf_ld  = 1'b1;
        alu_op = ALU_PASS_MDR;
      end
      S_BR_EXEC: begin
        rf_ld  = 1'b1;
        alu_op = ALU_PC_OFS;
      end
      S_BL_LINK: begin
        rf_ld  = 1'b1;
        alu_op = ALU_LINK;
      end
      S_FAULT:  fault = 1'b1;
      default:  ;
    endcase
  end

`ifdef CU_PERF_EN
  logic [31:0] retire_cnt;
  logic        retire;

  // Every entry to FETCH0 other than the one out of RESET retires an instruction.
  assign retire = (state_nx == S_FETCH0) && (state != S_RESET);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign instr_cnt = retire_cnt;
`else
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// tb_cu_sequencer: transaction-level model expands each instruction into its expected
// per-cycle control words; a negedge monitor pops and compares them against the DUT.
module tb_cu_sequencer;
  localparam int DATA_W      = 32;
  localparam int MOC_TIMEOUT = 15;
  localparam int OP_W        = 5;
`ifdef CU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [3:0] S_RESET = 4'd0, S_FETCH0 = 4'd1, S_FETCH1 = 4'd2, S_PC_INC = 4'd3;
  localparam logic [3:0] S_DECODE = 4'd4, S_DP_EXEC = 4'd5, S_LS_ADDR = 4'd6, S_LS_MEM = 4'd7;
  localparam logic [3:0] S_LD_WB = 4'd8, S_BR_EXEC = 4'd9, S_BL_LINK = 4'd10, S_FAULT = 4'd15;

  typedef struct packed {
    logic [3:0]      state;
    logic            rf_ld;
    logic            ir_ld;
    logic            mar_ld;
    logic            mdr_ld;
    logic            rw;
    logic            mov;
    logic [1:0]      data_type;
    logic            fr_ld;
    logic [OP_W-1:0] alu_op;
    logic            fault;
    logic [31:0]     instr_cnt;
  } rec_t;

  logic              CLK = 1'b0;
  logic              CLR = 1'b1;
  logic              moc = 1'b0;
  logic [DATA_W-1:0] ir = '0;
  logic [3:0]        flags = '0;
  logic              rf_ld, ir_ld, mar_ld, mdr_ld, rw, mov, fr_ld, fault;
  logic [1:0]        data_type;
  logic [OP_W-1:0]   alu_op;
  logic [3:0]        state;
  logic [31:0]       instr_cnt;

  always #5 CLK = ~CLK;

  cu_sequencer #(.DATA_W(DATA_W), .MOC_TIMEOUT(MOC_TIMEOUT), .OP_W(OP_W)) dut (
    .CLK(CLK), .CLR(CLR), .moc(moc), .ir(ir), .flags(flags),
    .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .rw(rw), .mov(mov),
    .data_type(data_type), .fr_ld(fr_ld), .alu_op(alu_op), .state(state), .fault(fault),
    .instr_cnt(instr_cnt)
  );

  rec_t exp_q[$];
  rec_t act;
  rec_t exp_r;
  int   checks = 0;
  int   failures = 0;
  int   cyc_no = 0;
  int   model_cnt = 0;

  assign act = {state, rf_ld, ir_ld, mar_ld, mdr_ld, rw, mov, data_type, fr_ld, alu_op, fault, instr_cnt};

  task automatic check(input string name, input rec_t got, input rec_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d: got=%h (state %0d) expected=%h (state %0d)",
               name, cyc_no, got, got.state, want, want.state);
    end
  endtask

  // Monitor: one expected control word per clock, compared mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      check("ctrl", act, exp_r);
    end
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic rec_t mk(input logic [3:0] s);
    rec_t r;
    r = '0;
    r.state = s;
    r.data_type = 2'b10;
    r.instr_cnt = PERF ? 32'(model_cnt) : 32'd0;
    return r;
  endfunction

  // Conditions come in complementary pairs: odd codes invert the even one.
  function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    bit base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic cyc(input rec_t e, input logic m);
    exp_q.push_back(e);
    moc = m;
    @(posedge CLK);
    #1;
    cyc_no++;
  endtask

  task automatic mem_phase(input rec_t e, input int w, output bit faulted);
    faulted = 1'b0;
    for (int i = 0; i < w && i <= MOC_TIMEOUT; i++) cyc(e, 1'b0);
    if (w > MOC_TIMEOUT) faulted = 1'b1;
    else cyc(e, 1'b1);
  endtask

  task automatic clr_into_reset(input rec_t e);
    CLR = 1'b1;
    cyc(e, 1'b1);
    CLR = 1'b0;
    model_cnt = 0;
    cyc(mk(S_RESET), rbit());
  endtask

  task automatic clr_now();
    rec_t e;
    e = mk(S_FETCH0);
    e.mar_ld = 1'b1;
    e.alu_op = 5'h11;
    clr_into_reset(e);
  endtask

  task automatic fault_then_clr();
    rec_t e;
    e = mk(S_FAULT);
    e.fault = 1'b1;
    for (int i = 0; i < 3; i++) cyc(e, rbit());
    clr_into_reset(e);
  endtask

  task automatic run_instr(input logic [31:0] iv, input logic [3:0] fv, input int wf, input int wm,
                           input bit clr_mem, output bit faulted);
    rec_t e;
    bit   f;
    ir = iv;
    flags = fv;
    faulted = 1'b0;
    e = mk(S_FETCH0); e.mar_ld = 1'b1; e.alu_op = 5'h11;
    cyc(e, rbit());
    e = mk(S_FETCH1); e.mov = 1'b1; e.rw = 1'b1; e.ir_ld = 1'b1;
    mem_phase(e, wf, f);
    if (f) begin faulted = 1'b1; return; end
    e = mk(S_PC_INC); e.rf_ld = 1'b1; e.alu_op = 5'h12;
    cyc(e, rbit());
    cyc(mk(S_DECODE), rbit());
    if (!cond_pass(iv[31:28], fv)) begin model_cnt++; return; end
    case (iv[27:26])
      2'b00: begin
        e = mk(S_DP_EXEC);
        e.alu_op = {1'b0, iv[24:21]};
        e.fr_ld = iv[20];
        e.rf_ld = !(iv[24:21] >= 4'd8 && iv[24:21] <= 4'd11);
        cyc(e, rbit());
        model_cnt++;
      end
      2'b01: begin
        e = mk(S_LS_ADDR); e.mar_ld = 1'b1; e.alu_op = iv[23] ? 5'h04 : 5'h02; e.mdr_ld = !iv[20];
        cyc(e, rbit());
        e = mk(S_LS_MEM); e.mov = 1'b1; e.rw = iv[20]; e.mdr_ld = iv[20];
        e.data_type = iv[22] ? 2'b00 : 2'b10;
        if (clr_mem) begin clr_into_reset(e); return; end
        mem_phase(e, wm, f);
        if (f) begin faulted = 1'b1; return; end
        if (iv[20]) begin
          e = mk(S_LD_WB); e.rf_ld = 1'b1; e.alu_op = 5'h13;
          cyc(e, rbit());
        end
        model_cnt++;
      end
      2'b10: begin
        e = mk(S_BR_EXEC); e.rf_ld = 1'b1; e.alu_op = 5'h10;
        cyc(e, rbit());
        if (iv[24]) begin
          e = mk(S_BL_LINK); e.rf_ld = 1'b1; e.alu_op = 5'h14;
          cyc(e, rbit());
        end
        model_cnt++;
      end
      default: faulted = 1'b1;
    endcase
  endtask

  task automatic do_instr(input logic [31:0] iv, input logic [3:0] fv, input int wf, input int wm,
                          input bit clr_mem);
    bit f;
    run_instr(iv, fv, wf, wm, clr_mem, f);
    if (f) fault_then_clr();
  endtask

  function automatic int rand_wait();
    int r;
    r = int'($urandom_range(0, 39));
    if (r < 30) return r % 3;
    if (r < 37) return int'($urandom_range(3, MOC_TIMEOUT));
    if (r < 39) return MOC_TIMEOUT;
    return MOC_TIMEOUT + 1;
  endfunction

  initial begin
    logic [31:0] iv;
    int          cls;
    CLR = 1'b1;
    moc = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b0;
    cyc(mk(S_RESET), 1'b1);

    do_instr(32'hE5D13002, 4'b0000, 0, 0, 1'b0);
    do_instr(32'hE0912003, 4'b0000, 0, 0, 1'b0);
    do_instr(32'h0A000004, 4'b0000, 0, 0, 1'b0);
    clr_now();
    do_instr(32'hE1510002, 4'b0000, 0, 0, 1'b0);
    do_instr(32'h0A000004, 4'b0100, 0, 0, 1'b0);
    do_instr(32'hEB000010, 4'b0000, 2, 0, 1'b0);
    do_instr(32'hE0912003, 4'b0000, MOC_TIMEOUT, 0, 1'b0);
    do_instr(32'hE0912003, 4'b0000, MOC_TIMEOUT + 1, 0, 1'b0);
    do_instr(32'hE5D13002, 4'b0000, 1, MOC_TIMEOUT, 1'b0);
    do_instr(32'hE5812000, 4'b0000, 0, MOC_TIMEOUT + 1, 1'b0);
    do_instr(32'hE5812000, 4'b0000, 0, 0, 1'b1);
    do_instr(32'hEC000000, 4'b0000, 0, 0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      iv = $urandom;
      if ($urandom_range(0, 1) == 0) iv[31:28] = 4'hE;
      cls = int'($urandom_range(0, 19));
      if (cls < 7)       iv[27:26] = 2'b00;
      else if (cls < 13) iv[27:26] = 2'b01;
      else if (cls < 19) iv[27:26] = 2'b10;
      else               iv[27:26] = 2'b11;
      if ($urandom_range(0, 29) == 0) clr_now();
      do_instr(iv, 4'($urandom_range(0, 15)), rand_wait(), rand_wait(),
               $urandom_range(0, 24) == 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Parametrised next-generation control unit for the ARM-subset datapath.
- Moore FSM sequencing fetch, decode, data-processing, load/store and branch.
- Evaluates the condition field against NZCV flags.
- Uses the MOV/MOC memory handshake with a bounded wait and a sticky fault state.
- Drives the load enables and mux/ALU selects for the register file, IR, MAR, MDR and flag register.

Parameters:
DATA_W, 32, instruction width; decode uses ir[31:20]; upper bits generalise future encodings (min 32)
MOC_TIMEOUT, 15, max cycles waiting for moc in a memory state before FAULT (1..255)
OP_W, 5, ALU opcode width

Ports:
CLK  input  1  clock, rising edge
CLR  input  1  synchronous active-high reset
moc  input  1  memory operation complete
ir  input  DATA_W  current instruction register contents
flags  input  4  {N,Z,C,V} from flag register
rf_ld  output  1  register file write enable
ir_ld  output  1  instruction register load
mar_ld  output  1  MAR load
mdr_ld  output  1  MDR load
rw  output  1  1=read, 0=write (valid while mov=1)
mov  output  1  memory operation valid
data_type  output  2  00 byte, 10 word
fr_ld  output  1  flag register load
alu_op  output  OP_W  ALU operation select
state  output  4  current state encoding (debug)
fault  output  1  high while in FAULT
instr_cnt  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- All outputs are combinational decodes of the registered state plus ir; no output depends on moc combinationally.
- Sync reset: state=RESET. All outputs 0 except data_type=10. Counters cleared.
- States and encodings:
  - RESET(0): -> FETCH0.
  - FETCH0(1): mar_ld=1, alu_op=11h (pass PC). -> FETCH1.
  - FETCH1(2): mov=1, rw=1, data_type=10. On moc: ir_ld=1, -> PC_INC.
  - PC_INC(3): rf_ld=1, alu_op=12h (PC+4). -> DECODE.
  - DECODE(4), no enables:
    - condition false: -> FETCH0 (instruction retired).
    - ir[27:26]=00 -> DP_EXEC; 01 -> LS_ADDR; 10 -> BR_EXEC; 11 -> FAULT.
  - DP_EXEC(5):
    - alu_op={0,ir[24:21]}; fr_ld=ir[20].
    - rf_ld=1 unless ir[24:21] in 1000..1011 (TST/TEQ/CMP/CMN).
    - -> FETCH0.
  - LS_ADDR(6):
    - mar_ld=1; alu_op=04h if ir[23] (U) else 02h.
    - Store (ir[20]=0): also mdr_ld=1.
    - -> LS_MEM.
  - LS_MEM(7):
    - mov=1, rw=ir[20], data_type = ir[22] ? 00 : 10.
    - On moc: load: mdr_ld=1, -> LD_WB; store: -> FETCH0.
  - LD_WB(8): rf_ld=1, alu_op=13h (pass MDR). -> FETCH0.
  - BR_EXEC(9): rf_ld=1, alu_op=10h (PC+offset). If ir[24] (BL), link write is a separate cycle BL_LINK(10, rf_ld=1, alu_op=14h) -> FETCH0; else -> FETCH0.
  - FAULT(15): fault=1, all enables 0. Exits only via CLR.
- Condition codes, ir[31:28]:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL true; 1111 false.
- Wait counter:
  - Cleared on entry to FETCH1/LS_MEM; increments each cycle moc=0.
  - When counter reaches MOC_TIMEOUT with moc=0: -> FAULT.
  - moc=1 in the same cycle the limit is reached: moc wins, normal transition.
- moc outside FETCH1/LS_MEM is ignored.
- CLR mid-memory-access: mov drops the cycle after the CLR edge; no ir_ld/mdr_ld is issued.
- Zero-wait timing (moc held 1):
  - DP: 5 cycles from FETCH0 to next FETCH0.
  - Load: 7. Store: 6. Branch: 5. Cond-fail: 4.

Optional Feature:
- Macro CU_PERF_EN.
- Defined: instr_cnt increments by 1 on every transition into FETCH0 from DECODE, DP_EXEC, LS_MEM (store), LD_WB, BR_EXEC or BL_LINK. It wraps modulo 2^32, is cleared by CLR and freezes in FAULT.
- Undefined: port still present, tied to 0, no counter logic.

Test Plan:
- CLR=1 two cycles, moc=1, ir=E5D13002 (LDRB, U=1, L=1) -> states 0,1,2,3,4,6,7,8,1; LS_ADDR alu_op=04h; LS_MEM mov=1 rw=1 data_type=00; LD_WB rf_ld=1.
- ir=E0912003 (ADDS r2), moc=1 -> DP_EXEC alu_op=04h, rf_ld=1, fr_ld=1; ir=E1510002 (CMP) -> rf_ld=0, fr_ld=1.
- ir=0A000004 (BEQ), flags Z=0 -> DECODE then FETCH0, no rf_ld; flags=4'b0100 -> BR_EXEC rf_ld=1 alu_op=10h.
- moc held 0 in FETCH1 with MOC_TIMEOUT=15 -> FAULT after 15 wait cycles, fault=1 until CLR; moc=1 exactly at count 15 -> PC_INC, no fault.
- CLR asserted during LS_MEM (store E5812000) -> next cycle state=0, mov=0, mdr_ld=0; then resumes at FETCH0.
- CU_PERF_EN defined: run 3 instructions (load, ADDS, cond-fail BEQ) -> instr_cnt=3; CLR -> 0.
